// File: rtl/ca_output_buffer.sv
// rtl/ca_output_buffer.sv - per-subchannel CA egress FIFO with even parity and minimum issue gap
module ca_output_buffer #(
  parameter int CA_WIDTH = 24,
  parameter int DEPTH    = 8,
  parameter int GAP_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [GAP_BITS-1:0]          min_gap,
  input  logic [CA_WIDTH-1:0]          ca_in,
  input  logic                         ca_valid_in,
  output logic                         ca_ready_out,
  output logic [CA_WIDTH-1:0]          ca_dram_out,
  output logic                         ca_par_out,
  output logic                         ca_valid_dram_out,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [31:0]                  issue_count,
  output logic                         gap_stall_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {ARMED, HOLDOFF} state_t;

  state_t                state;
  logic [GAP_BITS-1:0]   gap_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CA_WIDTH-1:0]   mem [DEPTH];
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [CA_WIDTH-1:0]   head;

  assign full         = (fifo_level == LW'(DEPTH));
  assign empty        = (fifo_level == '0);
  assign ca_ready_out = enable & ~flush & ~full;
  assign push         = ca_valid_in & ca_ready_out;
  assign pop          = enable & ~flush & ~empty & (state == ARMED);
  assign head         = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked solely by the level counter.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ca_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      state             <= ARMED;
      gap_cnt           <= '0;
      ca_dram_out       <= '0;
      ca_par_out        <= 1'b0;
      ca_valid_dram_out <= 1'b0;
      issue_count       <= '0;
      gap_stall_flag    <= 1'b0;
    end else if (flush) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      state             <= ARMED;
      gap_cnt           <= '0;
      ca_valid_dram_out <= 1'b0;
      gap_stall_flag    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + PW'(1);
        ca_dram_out       <= head;
        ca_par_out        <= ^head;
        ca_valid_dram_out <= 1'b1;
        issue_count       <= issue_count + 32'd1;
      end else begin
        ca_valid_dram_out <= 1'b0;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      gap_stall_flag <= (state == HOLDOFF) & ~empty;
      // The holdoff countdown runs independently of enable.
      case (state)
        ARMED: begin
          if (pop && (min_gap != '0)) begin
            state   <= HOLDOFF;
            gap_cnt <= min_gap;
          end
        end
        HOLDOFF: begin
          gap_cnt <= gap_cnt - GAP_BITS'(1);
          if (gap_cnt == GAP_BITS'(1)) begin
            state <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_output_buffer.sv
// tb/tb_ca_output_buffer.sv - randomized scoreboard bench for ca_output_buffer
module tb_ca_output_buffer;

  localparam int CW    = 24;
  localparam int DEPTH = 8;
  localparam int GB    = 4;

  logic            clk;
  logic            rst;
  logic            enable;
  logic            flush;
  logic [GB-1:0]   min_gap;
  logic [CW-1:0]   ca_in;
  logic            ca_valid_in;
  logic            ca_ready_out;
  logic [CW-1:0]   ca_dram_out;
  logic            ca_par_out;
  logic            ca_valid_dram_out;
  logic [3:0]      fifo_level;
  logic [31:0]     issue_count;
  logic            gap_stall_flag;

  ca_output_buffer #(.CA_WIDTH(CW), .DEPTH(DEPTH), .GAP_BITS(GB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .min_gap(min_gap),
    .ca_in(ca_in), .ca_valid_in(ca_valid_in), .ca_ready_out(ca_ready_out),
    .ca_dram_out(ca_dram_out), .ca_par_out(ca_par_out),
    .ca_valid_dram_out(ca_valid_dram_out), .fifo_level(fifo_level),
    .issue_count(issue_count), .gap_stall_flag(gap_stall_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a word queue plus the earliest edge at which the next issue is allowed.
  logic [CW-1:0] q[$];
  logic [CW-1:0] exp_q[$];
  int            t;
  int            allow_at;
  logic [31:0]   m_cnt;
  logic [CW-1:0] m_last;
  logic          m_valid;
  logic          m_stall;
  bit            mon_en;
  int            n_cmp;
  int            n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h want %h", name, t, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic fl, input logic v,
                      input logic [CW-1:0] d, input logic [GB-1:0] g);
    bit rdy;
    bit pushing;
    bit popping;
    logic [CW-1:0] w;
    rst = r; enable = en; flush = fl; ca_valid_in = v; ca_in = d; min_gap = g;
    #1;
    rdy = en && !fl && (q.size() < DEPTH);
    if (mon_en && !r) check("ready", {31'd0, ca_ready_out}, {31'd0, rdy});
    @(posedge clk);
    if (r) begin
      q.delete(); exp_q.delete();
      allow_at = 0; m_cnt = 0; m_last = '0; m_valid = 0; m_stall = 0;
    end else if (fl) begin
      q.delete();
      allow_at = 0; m_valid = 0; m_stall = 0;
    end else begin
      pushing = v && rdy;
      popping = en && (q.size() > 0) && (t >= allow_at);
      m_stall = (t < allow_at) && (q.size() > 0);
      if (popping) begin
        w = q.pop_front();
        exp_q.push_back(w);
        m_last = w;
        m_cnt++;
        m_valid = 1;
        allow_at = t + int'(g) + 1;
      end else begin
        m_valid = 0;
      end
      if (pushing) q.push_back(d);
    end
    t++;
    if (r) mon_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [GB-1:0] g);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, g);
  endtask

  always @(negedge clk) begin
    logic [CW-1:0] w;
    if (mon_en) begin
      check("valid", {31'd0, ca_valid_dram_out}, {31'd0, m_valid});
      check("level", {28'd0, fifo_level}, q.size());
      check("count", issue_count, m_cnt);
      check("stall", {31'd0, gap_stall_flag}, {31'd0, m_stall});
      check("hold_data", {8'd0, ca_dram_out}, {8'd0, m_last});
      if (ca_valid_dram_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {31'd0, ca_valid_dram_out}, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("sb_data", {8'd0, ca_dram_out}, {8'd0, w});
          check("sb_par", {31'd0, ca_par_out}, {31'd0, ^w});
        end
      end
    end
  end

  initial begin
    t = 0; allow_at = 0; m_cnt = 0; m_last = '0; m_valid = 0; m_stall = 0;
    mon_en = 0; n_cmp = 0; n_fail = 0;
    // reset
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    step(0, 1, 0, 0, '0, 0);
    // back-to-back issues with zero gap
    step(0, 1, 0, 1, 24'hA5A5A5, 0);
    step(0, 1, 0, 1, 24'h000001, 0);
    step(0, 1, 0, 1, 24'h123456, 0);
    idle(3, 0);
    check("t2_count", issue_count, 32'd3);
    // gap of 3 between issues
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, CW'($urandom), 3);
    idle(18, 3);
    // fill to full under a long gap
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, CW'($urandom), 15);
    idle(150, 15);
    // flush at level 5
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, CW'($urandom), 15);
    step(0, 1, 1, 1, 24'hFFFFFF, 15);
    idle(3, 0);
    // reset during holdoff
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, CW'($urandom), 15);
    step(1, 1, 0, 0, '0, 0);
    step(0, 1, 0, 1, 24'h00BEEF, 0);
    idle(3, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [GB-1:0] g;
      if ($urandom_range(0, 9) == 0) g = 4'd15;
      else if ($urandom_range(0, 2) == 0) g = 4'd0;
      else g = GB'($urandom_range(1, 5));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), CW'($urandom), g);
    end
    idle(150, 0);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
